// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply (radix-2 Booth) and divide (restoring) unit.
// Results land in HI/LO; one operation in flight at a time, done pulses once.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t      r_state, w_next;
    logic [64:0] r_acc;
    logic [31:0] r_m, r_quo, r_rem;
    logic [5:0]  r_cnt;
    logic        r_is_mult, r_dz, r_sa, r_sb;

    logic        w_start, w_last, w_hold, w_busy_nxt, w_done_nxt, w_qbit;
    logic [31:0] w_amag, w_bmag;
    logic [32:0] w_bsum, w_dshift;
    logic [33:0] w_ddiff;

    assign w_start = start_mult | start_div;
    assign w_last  = (r_cnt == 6'd31);
    // Divide-by-zero parks one extra cycle in DONE to keep its latency at two edges.
    assign w_hold  = r_dz && (r_cnt == 6'd0);
    assign w_amag  = a[31] ? -a : a;
    assign w_bmag  = b[31] ? -b : b;

    // Booth add/sub on a 33-bit A so that -2^31 operands cannot overflow the sign.
    always_comb begin
        w_bsum = {r_acc[64], r_acc[64:33]};
        case (r_acc[1:0])
            2'b01:   w_bsum = {r_acc[64], r_acc[64:33]} + {r_m[31], r_m};
            2'b10:   w_bsum = {r_acc[64], r_acc[64:33]} - {r_m[31], r_m};
            default: w_bsum = {r_acc[64], r_acc[64:33]};
        endcase
    end

    assign w_dshift = {r_rem, r_quo[31]};
    assign w_ddiff  = {1'b0, w_dshift} - {2'b00, r_m};
    assign w_qbit   = ~w_ddiff[33];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_mult)     w_next = MULT;
                else if (start_div) w_next = (b == 32'd0) ? DONE : DIV;
            end
            MULT:    if (w_last) w_next = DONE;
            DIV:     if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = w_hold ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt = (r_state == DONE) && !w_hold;
        case (r_state)
            IDLE:    w_busy_nxt = w_start;
            DONE:    w_busy_nxt = w_hold;
            default: w_busy_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_m       <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_is_mult <= 1'b0;
            r_dz      <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            div_zero <= w_done_nxt & r_dz;
            case (r_state)
                IDLE: if (w_start) begin
                    r_cnt     <= '0;
                    r_is_mult <= start_mult;
                    r_dz      <= !start_mult && (b == 32'd0);
                    r_acc     <= {32'd0, a, 1'b0};
                    r_m       <= start_mult ? b : w_bmag;
                    r_quo     <= w_amag;
                    r_rem     <= '0;
                    r_sa      <= a[31];
                    r_sb      <= b[31];
                end
                MULT: begin
                    r_acc <= {w_bsum, r_acc[32:1]};
                    if (!w_last) r_cnt <= r_cnt + 6'd1;
                end
                DIV: begin
                    r_rem <= w_qbit ? w_ddiff[31:0] : w_dshift[31:0];
                    r_quo <= {r_quo[30:0], w_qbit};
                    if (!w_last) r_cnt <= r_cnt + 6'd1;
                end
                FIX: begin
                    if (r_sa ^ r_sb) r_quo <= -r_quo;
                    if (r_sa)        r_rem <= -r_rem;
                end
                DONE: begin
                    if (w_hold) r_cnt <= 6'd1;
                    if (w_done_nxt && !r_dz) begin
                        hi <= r_is_mult ? r_acc[64:33] : r_rem;
                        lo <= r_is_mult ? r_acc[32:1]  : r_quo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operands,
// scored against plain 64-bit arithmetic with latency and handshake checks.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_mult, start_div;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input bit m, input bit d, input logic [31:0] xa, input logic [31:0] xb);
        start_mult = m;
        start_div  = d;
        a = xa;
        b = xb;
    endtask

    // Call with the start already driven; returns at #1 after the done edge.
    task automatic finish_op(input bit is_mult, input logic [31:0] xa, input logic [31:0] xb,
                             input int reassert_at);
        longint p, q, r;
        logic [31:0] e_hi, e_lo;
        bit e_dz, got;
        int lat, n;
        if (is_mult) begin
            p = longint'($signed(xa)) * longint'($signed(xb));
            e_hi = p[63:32]; e_lo = p[31:0]; e_dz = 0; lat = 33;
        end else if (xb == 32'd0) begin
            e_hi = m_hi; e_lo = m_lo; e_dz = 1; lat = 2;
        end else begin
            q = longint'($signed(xa)) / longint'($signed(xb));
            r = longint'($signed(xa)) % longint'($signed(xb));
            e_hi = r[31:0]; e_lo = q[31:0]; e_dz = 0; lat = 34;
        end
        @(posedge clk); #1;
        start_mult = 0; start_div = 0;
        chk("start_busy", {busy, done}, 2'b10);
        got = 0; n = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            a = $urandom; b = $urandom;
            start_mult = (c == reassert_at);
            @(posedge clk); #1;
            chk("busy_done_excl", busy & done, 1'b0);
            if (done) begin got = 1; n = c; end
            else chk("busy_held", busy, 1'b1);
        end
        start_mult = 0;
        chk("done_seen", got, 1'b1);
        chk("latency", n, lat);
        chk("hi", hi, e_hi);
        chk("lo", lo, e_lo);
        chk("div_zero", div_zero, e_dz);
        m_hi = e_hi; m_lo = e_lo;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit seen;
        rst = 1; start_mult = 0; start_div = 0; a = '0; b = '0;
        repeat (2) @(posedge clk); #1;
        chk("reset_state", {hi, lo, busy, done, div_zero}, 67'd0);
        @(negedge clk); rst = 0;

        @(negedge clk); start_op(1, 0, 32'd7, -32'sd3); finish_op(1, 32'd7, -32'sd3, 0);
        chk("mul_7x-3_hi", hi, 32'hFFFF_FFFF);
        chk("mul_7x-3_lo", lo, 32'hFFFF_FFEB);

        @(negedge clk); start_op(0, 1, -32'sd7, 32'd2); finish_op(0, -32'sd7, 32'd2, 0);
        chk("div_-7/2_lo", lo, 32'hFFFF_FFFD);

        @(negedge clk); start_op(0, 1, 32'h451, 32'h20); finish_op(0, 32'h451, 32'h20, 0);
        @(negedge clk); start_op(0, 1, 32'd5, 32'd0); finish_op(0, 32'd5, 32'd0, 0);
        chk("dz_keep", {hi, lo}, 64'h11_0000_0022);
        @(posedge clk); #1;
        chk("dz_one_pulse", {done, div_zero}, 2'b00);

        @(negedge clk); start_op(1, 1, 32'h8000_0000, 32'h8000_0000);
        finish_op(1, 32'h8000_0000, 32'h8000_0000, 0);
        chk("min_sq", {hi, lo}, 64'h4000_0000_0000_0000);

        @(negedge clk); start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("min_div_m1", {hi, lo}, 64'h0000_0000_8000_0000);

        // Re-issued start while busy is ignored; a start in the done cycle chains.
        ra = $urandom; rb = $urandom;
        @(negedge clk); start_op(1, 0, ra, rb); finish_op(1, ra, rb, 5);
        ra = $urandom; rb = $urandom | 32'd1;
        start_op(0, 1, ra, rb); finish_op(0, ra, rb, 0);
        @(posedge clk); #1;
        chk("idle_after_chain", {busy, done}, 2'b00);

        // Reset mid-divide.
        @(negedge clk); start_op(0, 1, 32'd100, 32'd7);
        @(posedge clk); #1; start_mult = 0; start_div = 0;
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1 chk("async_reset", {hi, lo, busy, done, div_zero}, 67'd0);
        start_mult = 1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        chk("start_in_reset", {busy, done}, 2'b00);
        @(negedge clk); rst = 0; start_mult = 0;
        m_hi = '0; m_lo = '0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("no_done_after_abort", seen, 1'b0);
        @(negedge clk); start_op(1, 0, 32'd3, 32'd4); finish_op(1, 32'd3, 32'd4, 0);
        chk("mul_3x4", {hi, lo}, 64'd12);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 4 == 1) rb = $urandom_range(0, 15) - 32'd8;
            if (i % 5 == 4) rb = 32'd0;
            if (i % 6 == 2) ra = 32'h8000_0000;
            @(negedge clk);
            if (i % 2 == 0) begin start_op(1, 0, ra, rb); finish_op(1, ra, rb, 0); end
            else            begin start_op(0, 1, ra, rb); finish_op(0, ra, rb, 0); end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: start_mult  input  1  request signed multiply of a*b; sampled on a rising edge.
REQ-004 SHALL have port: start_div  input  1  request signed divide a/b; sampled on a rising edge.
REQ-005 SHALL have port: a  input  32  operand A, two's complement; dividend for divide.
REQ-006 SHALL have port: b  input  32  operand B, two's complement; divisor for divide.
REQ-007 SHALL have port: hi  output  32  HI register: product[63:32] or remainder.
REQ-008 SHALL have port: lo  output  32  LO register: product[31:0] or quotient.
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: div_zero  output  1  one-cycle pulse, with done, for divide by zero.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, FIX, DONE; every output registered.
REQ-013 SHALL, in IDLE, capture a and b into internal registers on the edge that samples a start, clear the iteration counter, set busy, and go to MULT or DIV.
REQ-014 SHALL give start_mult priority when start_mult and start_div are both high in the same cycle; start_div is dropped.
REQ-015 SHALL ignore start_mult and start_div in every state other than IDLE; no queuing.
REQ-016 SHALL, in MULT, run radix-2 Booth, one step per cycle, 32 steps with a 6-bit counter 0..31, on a 65-bit accumulator {A, Q, q-1}, then go to DONE.
REQ-017 SHALL produce the exact 64-bit signed product, including -2^31 * -2^31 = 0x4000_0000_0000_0000.
REQ-018 SHALL, in DIV, run restoring division on operand magnitudes, one quotient bit per cycle, 32 steps, then go to FIX.
REQ-019 SHALL, in FIX, negate the quotient if the operand signs differ, give the remainder the dividend's sign, then go to DONE.
REQ-020 SHALL return lo=0x8000_0000, hi=0 for -2^31 / -1, with no overflow flag.
REQ-021 SHALL, for a divide with b==0, go from IDLE directly to DONE, leave hi and lo unchanged, and pulse div_zero together with done.
REQ-022 SHALL, in DONE, write hi/lo (except the div-by-zero case), pulse done for exactly one cycle, clear busy, and return to IDLE.
REQ-023 SHALL set latency, with start sampled at edge k: multiply done high after edge k+33; divide after edge k+34; div-by-zero after edge k+2.
REQ-024 SHALL keep busy high from edge k until the edge that asserts done; busy and done SHALL never be high in the same cycle.
REQ-025 SHALL update hi/lo only on the edge that asserts done; otherwise they hold their last result.
REQ-026 SHALL accept a new start in the cycle done is high; that start is sampled in IDLE on the following edge.
REQ-027 SHALL ignore changes on a/b after capture.

Reset
REQ-028 SHALL, on rst high, immediately and asynchronously force state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
REQ-029 SHALL, on reset mid-operation, abort the operation without producing done; reset held across a rising edge ignores starts.
REQ-030 SHALL treat the first rising edge after rst falls as a normal IDLE cycle.

Verification
REQ-031 SHALL cover: start_mult, a=7, b=-3 -> done at k+33, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB, busy high k..k+32.
REQ-032 SHALL cover: start_div, a=-7, b=2 -> done at k+34, lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
REQ-033 SHALL cover: start_div, a=5, b=0, prior hi/lo=0x11/0x22 -> done and div_zero pulse at k+2, hi=0x11, lo=0x22.
REQ-034 SHALL cover: start_mult and start_div together, a=0x8000_0000, b=0x8000_0000 -> multiply only, hi=0x4000_0000, lo=0.
REQ-035 SHALL cover: start_div issued, rst pulsed at k+10 -> outputs zero immediately, no done, next start_mult a=3 b=4 gives lo=12, hi=0.
REQ-036 SHALL cover: start_mult re-asserted at k+5 during busy -> ignored, single done at k+33; back-to-back start in the done cycle accepted.
